topview_seg_reader: RTL and testbench
=====================================

// Module: topview_seg_reader
//
// PURPOSE
//   Sequences readout of the topview line-segment BRAM once a frame's segment list is complete.
//   - Starts on the rising edge of the topview ready flag.
//   - Walks read addresses 0..line_num-1 and absorbs the 1-cycle BRAM read latency.
//   - Unpacks each entry and streams segments to the downstream consumer over a valid/ready handshake.
//   Sits between the topview block's BRAM read port and the lane/path-planning logic.
//
// PARAMETERS
//   OUT_WIDTH   640   topview image width; HB = $clog2(OUT_WIDTH)
//   OUT_HEIGHT  480   topview image height; VB = $clog2(OUT_HEIGHT)
//   RAM_SIZE    4096  BRAM depth; AW = $clog2(RAM_SIZE); DW = 2*(VB+HB)+1
//
// PORTS
//   clk          in   1   clock
//   n_rst        in   1   reset, synchronous, active-low
//   tv_ready     in   1   topview list complete (level)
//   tv_line_num  in   AW  number of entries written this frame
//   tv_raddr     out  AW  BRAM read address; data appears on tv_rdata 1 cycle later
//   tv_rdata     in   DW  packed entry: {sv[VB], sh[HB], ev[VB], eh[HB], inrange}
//   seg_valid    out  1   segment available
//   seg_ready    in   1   consumer accepts
//   seg_start_v  out  VB  start row
//   seg_start_h  out  HB  start column
//   seg_end_v    out  VB  end row
//   seg_end_h    out  HB  end column
//   seg_inrange  out  1   entry inrange bit
//   busy         out  1   scan in progress
//   frame_done   out  1   1-cycle pulse: all entries issued and accepted
//   abort        out  1   1-cycle pulse: scan killed by tv_ready falling
//   seg_count    out  AW  segments accepted this scan; cleared at scan start
//
// BEHAVIOUR
//   Reset values: all outputs 0, tv_raddr 0, FSM in IDLE, FIFO empty, no read in flight.
//   FSM states:
//     - IDLE: on tv_ready 0->1 (registered edge detect), latch tv_line_num into N, clear the index and seg_count.
//       If N==0, pulse frame_done and go to WAIT_LOW; otherwise go to SCAN.
//     - SCAN: issue a read (tv_raddr<=idx, idx++) when idx<N and fifo_count+inflight<2.
//       - Each rdata is pushed into the 2-entry FIFO the cycle after issue.
//       - When idx==N, inflight==0, FIFO empty and the last beat has been accepted: pulse frame_done and go to WAIT_LOW.
//     - WAIT_LOW: hold until tv_ready==0, then go to IDLE. Exactly one scan per ready edge.
//   Throughput: 1 segment/cycle with seg_ready held high.
//   Latency: tv_ready rise -> first seg_valid = 3 cycles (edge detect, issue, push).
//   Handshake:
//     - A beat transfers on seg_valid&&seg_ready.
//     - The seg_* fields are the FIFO head and stay stable while seg_valid && !seg_ready.
//     - Push and pop in the same cycle are legal and keep the count unchanged.
//   seg_count increments on each transfer and wraps at 2^AW.
//   busy = (state==SCAN).
//   tv_line_num is sampled only at scan start; later changes are ignored.
//   Abort: tv_ready==0 in SCAN.
//     - Next cycle: FIFO flushed, in-flight read discarded, seg_valid=0, abort=1, state=IDLE, frame_done not pulsed.
//     - Dropping seg_valid without a transfer is intended here, because the list is being overwritten.
//   Simultaneous last transfer and tv_ready fall: the transfer counts, and frame_done wins over abort.
//   Reset mid-scan: return to the reset state next cycle, with no pulses.
//
// CONFIGURATION
//   TOPVIEW_SEG_SKIP_INVALID_EN defined:
//     - Entries with inrange==0 are dropped at FIFO push and never presented.
//     - seg_count counts forwarded segments only; seg_inrange reads 1 whenever seg_valid.
//   Macro undefined: every entry is forwarded; seg_inrange carries the stored bit.
//
// TESTING
//   - N=5, seg_ready=1, all inrange: tv_raddr 0..4 on consecutive cycles; 5 beats back-to-back from cycle 3;
//     frame_done 1 cycle after the last beat; seg_count=5.
//   - N=4, seg_ready low for 6 cycles during beat 1: fields stable, no more than 2 reads outstanding, no loss or
//     duplication; order 0,1,2,3 preserved.
//   - N=0 at tv_ready rise: frame_done pulses, no reads, seg_valid stays 0; a second pulse requires tv_ready low then high.
//   - N=8, tv_ready drops after 3 transfers: abort pulses, seg_valid=0 next cycle, seg_count=3, IDLE;
//     a new rise with N=2 scans cleanly from address 0.
//   - N=4 with entries 1 and 3 inrange=0: with _EN, 2 beats (entries 0, 2) and seg_count=2;
//     without _EN, 4 beats with seg_inrange=1,0,1,0.
//   - n_rst asserted mid-scan with a full FIFO: all outputs 0 next cycle; a following scan is correct.

Source files
------------

// File: rtl/topview_seg_reader_if.sv
// topview_seg_reader_if: bundle of the topview BRAM read port and the segment stream.
//   master: the reader (drives tv_raddr and the seg_* stream, receives tv_* and seg_ready)
//   slave : the environment (topview block + downstream consumer)
//   tv_ready, tv_line_num, tv_raddr, tv_rdata : BRAM side
//   seg_valid, seg_ready, seg_start_v/h, seg_end_v/h, seg_inrange : stream side
interface topview_seg_reader_if #(
  parameter int HB = 10,
  parameter int VB = 9,
  parameter int AW = 12
);
  localparam int DW = 2 * (VB + HB) + 1;
  logic tv_ready;
  logic [AW-1:0] tv_line_num;
  logic [AW-1:0] tv_raddr;
  logic [DW-1:0] tv_rdata;
  logic seg_valid;
  logic seg_ready;
  logic [VB-1:0] seg_start_v;
  logic [HB-1:0] seg_start_h;
  logic [VB-1:0] seg_end_v;
  logic [HB-1:0] seg_end_h;
  logic seg_inrange;
  modport master (
    input tv_ready, tv_line_num, tv_rdata, seg_ready,
    output tv_raddr, seg_valid, seg_start_v, seg_start_h, seg_end_v, seg_end_h, seg_inrange
  );
  modport slave (
    output tv_ready, tv_line_num, tv_rdata, seg_ready,
    input tv_raddr, seg_valid, seg_start_v, seg_start_h, seg_end_v, seg_end_h, seg_inrange
  );
endinterface

// File: rtl/topview_seg_reader.sv
// topview_seg_reader: on a rising tv_ready, read BRAM entries 0..N-1 and stream them as segments.
//   clk, n_rst (sync, active-low)
//   bus        : topview_seg_reader_if.master (BRAM read port + valid/ready segment stream)
//   busy       : scan in progress
//   frame_done : pulse, every entry issued and accepted
//   abort      : pulse, scan killed by tv_ready falling
//   seg_count  : segments accepted in the current scan
//   Optional: TOPVIEW_SEG_SKIP_INVALID_EN drops entries whose inrange bit is 0.
module topview_seg_reader #(
  parameter int OUT_WIDTH = 640,
  parameter int OUT_HEIGHT = 480,
  parameter int RAM_SIZE = 4096
) (
  input  logic clk,
  input  logic n_rst,
  topview_seg_reader_if.master bus,
  output logic busy,
  output logic frame_done,
  output logic abort,
  output logic [$clog2(RAM_SIZE)-1:0] seg_count
);
  localparam int HB = $clog2(OUT_WIDTH);
  localparam int VB = $clog2(OUT_HEIGHT);
  localparam int AW = $clog2(RAM_SIZE);
  localparam int DW = 2 * (VB + HB) + 1;
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, WAIT_LOW = 2'd2;
  logic [1:0] state, state_nx;
  logic rdy_q, inflight, rd, wr;
  logic [1:0] cnt;
  logic [AW-1:0] n, idx;
  logic [DW-1:0] mem [2];
  logic [DW-1:0] head;
  logic rise, start, pop, push, issue, done, kill;
  always_comb begin
    rise = bus.tv_ready && !rdy_q;
    start = state == IDLE && rise;
    pop = cnt != 2'd0 && bus.seg_ready;
`ifdef TOPVIEW_SEG_SKIP_INVALID_EN
    push = inflight && bus.tv_rdata[0];
`else
    push = inflight;
`endif
    // occupancy after this cycle's pop must leave room for the read being issued
    issue = state == SCAN && idx < n && ({1'b0, cnt} + {2'b0, inflight}) < ({2'b0, pop} + 3'd2);
    // the last beat leaving this cycle already counts as complete, so done beats a concurrent abort
    done = state == SCAN && idx == n && !inflight && (cnt == 2'd0 || (cnt == 2'd1 && pop));
    kill = state == SCAN && !bus.tv_ready && !done;
    head = mem[rd];
    state_nx = state == IDLE ? (rise ? (bus.tv_line_num == '0 ? WAIT_LOW : SCAN) : IDLE) :
               state == SCAN ? (done ? WAIT_LOW : (kill ? IDLE : SCAN)) :
               (bus.tv_ready ? WAIT_LOW : IDLE);
  end
  assign busy = state == SCAN;
  assign bus.tv_raddr = idx;
  assign bus.seg_valid = cnt != 2'd0;
  assign {bus.seg_start_v, bus.seg_start_h, bus.seg_end_v, bus.seg_end_h, bus.seg_inrange} =
    bus.seg_valid ? head : '0;
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= bus.tv_rdata;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
      inflight <= 1'b0;
      rd <= 1'b0;
      wr <= 1'b0;
      cnt <= 2'd0;
      n <= '0;
      idx <= '0;
      frame_done <= 1'b0;
      abort <= 1'b0;
      seg_count <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= bus.tv_ready;
      frame_done <= done || (start && bus.tv_line_num == '0);
      abort <= kill;
      inflight <= issue && !kill;
      idx <= start ? '0 : (issue ? idx + AW'(1) : idx);
      seg_count <= start ? '0 : (pop ? seg_count + AW'(1) : seg_count);
      if (start) n <= bus.tv_line_num;
      wr <= kill ? 1'b0 : wr ^ push;
      rd <= kill ? 1'b0 : rd ^ pop;
      cnt <= kill ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_topview_seg_reader.sv
// tb_topview_seg_reader: directed scoreboard bench for topview_seg_reader with a 1-cycle BRAM model.
module tb_topview_seg_reader;
  localparam int HB = 10, VB = 9, AW = 12, DW = 2 * (VB + HB) + 1;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic busy, frame_done, abort;
  logic [AW-1:0] seg_count;
  logic [DW-1:0] ram [4096];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] prev;
  logic hold_prev = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  topview_seg_reader_if #(.HB(HB), .VB(VB), .AW(AW)) bus ();
  topview_seg_reader dut (
    .clk(clk), .n_rst(n_rst), .bus(bus),
    .busy(busy), .frame_done(frame_done), .abort(abort), .seg_count(seg_count)
  );
  always @(posedge clk) bus.tv_rdata <= ram[bus.tv_raddr];
  function automatic logic [DW-1:0] ent(input int i, input logic inr);
    return {VB'(i + 1), HB'(3 * i), VB'(i + 100), HB'(7 * i + 1), inr};
  endfunction
  function automatic logic [DW-1:0] cur_seg();
    return {bus.seg_start_v, bus.seg_start_h, bus.seg_end_v, bus.seg_end_h, bus.seg_inrange};
  endfunction
  always @(negedge clk) begin
    if (!n_rst) hold_prev = 1'b0;
    else begin
      if (hold_prev && !abort) begin
        n_cmp++;
        if (!bus.seg_valid || cur_seg() !== prev) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b seg=%h, want valid=1 seg=%h", bus.seg_valid, cur_seg(), prev);
        end
      end
      if (bus.seg_valid && bus.seg_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: got seg=%h, want no beat", cur_seg());
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (cur_seg() !== e) begin
            n_err++;
            $display("FAIL beat: got seg=%h, want %h", cur_seg(), e);
          end
        end
      end
      hold_prev = bus.seg_valid && !bus.seg_ready;
      prev = cur_seg();
    end
  end
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask
  task automatic load(input int base, input int cnt, input logic [7:0] inr, input int keep);
    for (int a = 0; a < cnt; a++) begin
      ram[a] = ent(base + a, inr[a]);
`ifdef TOPVIEW_SEG_SKIP_INVALID_EN
      if (a < keep && inr[a]) exp_q.push_back(ram[a]);
`else
      if (a < keep) exp_q.push_back(ram[a]);
`endif
    end
  endtask
  task automatic start(input int cnt);
    bus.tv_line_num = AW'(cnt);
    bus.tv_ready = 1'b1;
  endtask
  task automatic wait_done(input string name, input int max);
    int c = 0;
    while (!frame_done && c < max) begin
      tick(1);
      c++;
    end
    chk(name, frame_done, 1);
  endtask
  task automatic end_scan();
    bus.tv_ready = 1'b0;
    tick(2);
  endtask
  initial begin
    bus.tv_ready = 1'b0;
    bus.tv_line_num = '0;
    bus.seg_ready = 1'b0;
    tick(3);
    chk("rst_outs", {busy, frame_done, abort, bus.seg_valid}, 0);
    chk("rst_count", seg_count, 0);
    chk("rst_raddr", bus.tv_raddr, 0);
    chk("rst_fields", cur_seg(), 0);
    n_rst = 1'b1;
    tick(1);
    // N=5 streaming at full rate
    bus.seg_ready = 1'b1;
    load(0, 5, 8'hff, 5);
    start(5);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (k <= 5) chk("t1_raddr", bus.tv_raddr, k - 1);
      chk("t1_valid", bus.seg_valid, k >= 3 && k <= 7);
      chk("t1_done", frame_done, k == 8);
      chk("t1_busy", busy, k <= 7);
    end
    chk("t1_count", seg_count, 5);
    chk("t1_drained", exp_q.size(), 0);
    end_scan();
    // N=4 with a 6-cycle stall on beat 1
    load(10, 4, 8'hff, 4);
    start(4);
    tick(4);
    bus.seg_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("t2_outstanding", AW'(bus.tv_raddr - seg_count), 2);
      tick(1);
    end
    bus.seg_ready = 1'b1;
    wait_done("t2_done", 20);
    chk("t2_count", seg_count, 4);
    chk("t2_drained", exp_q.size(), 0);
    end_scan();
    // N=0: immediate frame_done, one pulse per rising edge
    start(0);
    tick(1);
    chk("t3_done", frame_done, 1);
    chk("t3_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("t3_no_repulse", frame_done, 0);
      chk("t3_valid", bus.seg_valid, 0);
      chk("t3_raddr", bus.tv_raddr, 0);
    end
    chk("t3_count", seg_count, 0);
    bus.tv_ready = 1'b0;
    tick(1);
    bus.tv_ready = 1'b1;
    tick(1);
    chk("t3_done2", frame_done, 1);
    end_scan();
    // N=8 aborted after 3 transfers, then a clean N=2 scan
    load(20, 8, 8'hff, 3);
    start(8);
    tick(6);
    bus.seg_ready = 1'b0;
    bus.tv_ready = 1'b0;
    chk("t4_pending", bus.seg_valid, 1);
    tick(1);
    chk("t4_abort", abort, 1);
    chk("t4_valid", bus.seg_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", frame_done, 0);
    chk("t4_count", seg_count, 3);
    tick(1);
    chk("t4_abort_pulse", abort, 0);
    chk("t4_drained", exp_q.size(), 0);
    load(30, 2, 8'hff, 2);
    bus.seg_ready = 1'b1;
    start(2);
    tick(1);
    chk("t4b_raddr0", bus.tv_raddr, 0);
    tick(1);
    chk("t4b_raddr1", bus.tv_raddr, 1);
    wait_done("t4b_done", 20);
    chk("t4b_count", seg_count, 2);
    chk("t4b_drained", exp_q.size(), 0);
    end_scan();
    // N=4, entries 1 and 3 out of range
    load(40, 4, 8'b0101, 4);
    start(4);
    wait_done("t5_done", 20);
`ifdef TOPVIEW_SEG_SKIP_INVALID_EN
    chk("t5_count", seg_count, 2);
`else
    chk("t5_count", seg_count, 4);
`endif
    chk("t5_drained", exp_q.size(), 0);
    end_scan();
    // reset with a full FIFO, then a clean N=3 scan
    bus.seg_ready = 1'b0;
    load(50, 6, 8'hff, 0);
    start(6);
    tick(5);
    chk("t6_full", bus.seg_valid, 1);
    chk("t6_outstanding", AW'(bus.tv_raddr - seg_count), 2);
    n_rst = 1'b0;
    bus.tv_ready = 1'b0;
    tick(1);
    n_rst = 1'b1;
    chk("t6_outs", {busy, frame_done, abort, bus.seg_valid}, 0);
    chk("t6_count", seg_count, 0);
    chk("t6_raddr", bus.tv_raddr, 0);
    chk("t6_fields", cur_seg(), 0);
    tick(1);
    chk("t6_no_pulse", {frame_done, abort}, 0);
    load(60, 3, 8'hff, 3);
    bus.seg_ready = 1'b1;
    start(3);
    wait_done("t6b_done", 20);
    chk("t6b_count", seg_count, 3);
    chk("t6b_drained", exp_q.size(), 0);
    end_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
